// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses in a small FIFO for decode, and handles redirects by discarding stale fetches.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jflag_in,
    input  logic [31:0] jaddr_in,
    input  logic        hold_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]      pc;
    logic [31:0]      resp_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_nxt;
    logic [OUT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      data_mem [FIFO_DEPTH];
    logic [31:0]      pc_mem   [FIFO_DEPTH];
    logic [31:0]      in_use;
    logic             fire;
    logic             push;
    logic             pop;

    // Credits count both in-flight requests and buffered entries, so a push never overflows.
    assign in_use    = 32'(outstanding) + 32'(fifo_count);
    assign imem_req  = rst & ~hold_in & ~jflag_in
                     & (outstanding < OUT_W'(MAX_OUTSTANDING))
                     & (in_use < FIFO_DEPTH);
    assign imem_addr = pc;

    assign fire       = imem_req & imem_gnt;
    assign push       = imem_rvalid & (discard == '0) & ~jflag_in;
    assign inst_valid = (fifo_count != '0);
    assign pop        = inst_valid & inst_ready & ~jflag_in;
    assign inst_data  = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    always_comb begin
        outstanding_nxt = outstanding;
        case ({fire, imem_rvalid})
            2'b10:   outstanding_nxt = outstanding + OUT_W'(1);
            2'b01:   outstanding_nxt = outstanding - OUT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // PC, response tracking and FIFO pointers; a redirect marks every in-flight fetch stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (jflag_in) begin
                pc         <= {jaddr_in[31:2], 2'b00};
                resp_pc    <= {jaddr_in[31:2], 2'b00};
                discard    <= outstanding_nxt;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (fire) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - OUT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model plus a queue-based reference of the fetch stage,
// directed scenarios with literal expectations and a long randomized run.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int MAX_OUT = 2;
    localparam int DEPTH   = 2;

    logic        clk;
    logic        rst;
    logic        jflag_in;
    logic [31:0] jaddr_in;
    logic        hold_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    if_fetch_unit #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .jflag_in(jflag_in), .jaddr_in(jaddr_in), .hold_in(hold_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
    } flight_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    // Reference state: in-flight requests (also serve as the memory queue), buffered instructions, next PC.
    flight_t     mq[$];
    entry_t      fq[$];
    logic [31:0] m_pc;

    logic [31:0] fired_log[$];
    logic [31:0] deliv_log[$];
    int          cyc;
    int          first_fire_cyc;
    int          first_valid_cyc;
    int          n_total;
    int          n_pass;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 32'hDEAD_BEEF;
        return q[i];
    endfunction

    function automatic logic model_req();
        return rst && !hold_in && !jflag_in && (mq.size() < MAX_OUT) && (mq.size() + fq.size() < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    task automatic clear_logs();
        fired_log.delete();
        deliv_log.delete();
        first_fire_cyc  = -1;
        first_valid_cyc = -1;
        cyc = 0;
    endtask

    task automatic model_update(input logic ereq);
        flight_t e;
        logic    vpre;
        e = '0;
        vpre = (fq.size() != 0);
        if (imem_rvalid) e = mq.pop_front();
        if (jflag_in) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_pc = {jaddr_in[31:2], 2'b00};
        end else begin
            if (vpre && inst_ready) void'(fq.pop_front());
            if (imem_rvalid && !e.stale) fq.push_back('{data: mem_data(e.addr), pc: e.addr});
            if (ereq && imem_gnt) begin
                mq.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle: compare at negedge against the reference, then advance the reference at posedge.
    task automatic step();
        logic ereq;
        @(negedge clk);
        ereq = model_req();
        chk("imem_req", 32'(imem_req), 32'(ereq));
        chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("inst_data", inst_data, fq[0].data);
            chk("inst_pc", inst_pc, fq[0].pc);
        end
        if (imem_req && imem_gnt) begin
            fired_log.push_back(imem_addr);
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid && inst_ready && !jflag_in) deliv_log.push_back(inst_pc);
        @(posedge clk);
        model_update(ereq);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic hold, input logic jf, input logic [31:0] ja,
                         input logic gnt, input logic rv_en, input logic rdy);
        hold_in     = hold;
        jflag_in    = jf;
        jaddr_in    = ja;
        imem_gnt    = gnt;
        inst_ready  = rdy;
        imem_rvalid = rv_en && (mq.size() != 0);
        imem_rdata  = imem_rvalid ? mem_data(mq[0].addr) : 32'h0;
        step();
    endtask

    task automatic reset_dut();
        hold_in = 1'b0; jflag_in = 1'b0; jaddr_in = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        mq.delete();
        fq.delete();
        m_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int n;
    logic [31:0] last;

    initial begin
        n_total = 0; n_pass = 0;
        rst = 1'b1;
        clear_logs();
        #2;
        reset_dut();

        // Streaming with single-cycle memory and an always-ready decoder.
        clear_logs();
        repeat (9) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stream_fetch_addr", qget(fired_log, i), 32'(i * 4));
            chk("stream_deliv_pc", qget(deliv_log, i), 32'(i * 4));
        end
        chk("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);

        // Decoder stalled: credit limit stops fetch at two, then drains in order.
        reset_dut();
        clear_logs();
        repeat (6) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("stall_fetch_count", 32'(fired_log.size()), 32'd2);
        chk("stall_req_low", 32'(imem_req), 32'h0);
        chk("stall_fifo_full_valid", 32'(inst_valid), 32'h1);
        repeat (4) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("drain_count", 32'(deliv_log.size()), 32'd2);
        chk("drain_pc0", qget(deliv_log, 0), 32'h0);
        chk("drain_pc1", qget(deliv_log, 1), 32'h4);

        // Redirect with 0x8 and 0xC in flight.
        reset_dut();
        clear_logs();
        repeat (2) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("pre_jump_fetch_c", qget(fired_log, 3), 32'hC);
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1, 1'b1);
        chk("jump_addr", imem_addr, 32'h100);
        repeat (6) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("jump_fetch", qget(fired_log, 4), 32'h100);
        chk("jump_deliv0", qget(deliv_log, 0), 32'h0);
        chk("jump_deliv1", qget(deliv_log, 1), 32'h4);
        chk("jump_deliv2", qget(deliv_log, 2), 32'h100);

        // Hold mid-stream.
        reset_dut();
        clear_logs();
        repeat (6) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        n = fired_log.size();
        last = qget(fired_log, n - 1);
        repeat (5) drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("hold_no_fetch", 32'(fired_log.size()), 32'(n));
        chk("hold_drained", 32'(inst_valid), 32'h0);
        repeat (3) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("hold_resume_addr", qget(fired_log, n), last + 32'd4);

        // Redirect while held.
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        n = fired_log.size();
        repeat (3) drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("jhold_no_fetch", 32'(fired_log.size()), 32'(n));
        chk("jhold_addr", imem_addr, 32'h200);
        chk("jhold_req_low", 32'(imem_req), 32'h0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("jhold_first_fetch", qget(fired_log, n), 32'h200);

        // PC wrap, then reset with requests in flight.
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        n = fired_log.size();
        repeat (6) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("wrap_f8", qget(fired_log, n), 32'hFFFF_FFF8);
        chk("wrap_fc", qget(fired_log, n + 1), 32'hFFFF_FFFC);
        chk("wrap_00", qget(fired_log, n + 2), 32'h0000_0000);
        for (int i = 0; i < 6 && mq.size() < 2; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        reset_dut();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic checked every cycle against the reference.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                reset_dut();
            end else begin
                drive($urandom_range(0, 9) == 0,
                      $urandom_range(0, 29) == 0,
                      $urandom(),
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
